// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM register, runs one load/store on a request/response data
// bus, extracts and extends load data, and drives WB / ID-forwarding results.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [31:0] ex_pc,
    input  logic        ex_mem_en,
    input  logic [3:0]  ex_mem_wen,
    input  logic [2:0]  ex_load_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_sel_rf_res,
    input  logic        ex_rf_we,
    input  logic [4:0]  ex_rf_waddr,
    input  logic        ex_hi_we,
    input  logic        ex_lo_we,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    output logic        dbus_req,
    output logic [3:0]  dbus_wen,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_addr_ok,
    input  logic        dbus_data_ok,
    input  logic [31:0] dbus_rdata,
    output logic        stallreq_for_mem,
    output logic [31:0] wb_pc,
    output logic        wb_rf_we,
    output logic [4:0]  wb_rf_waddr,
    output logic [31:0] wb_rf_wdata,
    output logic        wb_hi_we,
    output logic        wb_lo_we,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo
);

    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LH  = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef struct packed {
        logic [31:0] pc;
        logic        mem_en;
        logic [3:0]  mem_wen;
        logic [2:0]  load_op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } exmem_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    exmem_t      r;
    exmem_t      ex_in;
    state_t      state;
    state_t      next_state;
    logic [31:0] rdata_buf;
    logic [31:0] raw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        load_new;
    logic        bubble;
    logic        reg_load;
    logic        resp_now;
    logic        unused_stall;

    // Only the EX/MEM and MEM/WB hold bits matter to this stage.
    assign unused_stall = ^{stall[5], stall[2:0]};

    assign ex_in = '{pc: ex_pc, mem_en: ex_mem_en, mem_wen: ex_mem_wen,
                     load_op: ex_load_op, addr: ex_addr, wdata: ex_wdata,
                     sel_rf_res: ex_sel_rf_res, rf_we: ex_rf_we,
                     rf_waddr: ex_rf_waddr, hi_we: ex_hi_we, lo_we: ex_lo_we,
                     hi: ex_hi, lo: ex_lo};

    // EX stalled but MEM/WB running means a bubble enters this stage.
    assign load_new = ~stall[3];
    assign bubble   = stall[3] & ~stall[4];
    assign reg_load = load_new | bubble;
    assign resp_now = (state == S_WAIT) & dbus_data_ok;

    // EX/MEM pipeline register: bubble, load or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r <= '0;
        else if (bubble)
            r <= '0;
        else if (load_new)
            r <= ex_in;
    end

    // Access FSM state and response buffer (kept for DONE while held).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rdata_buf <= '0;
        end else begin
            state <= next_state;
            if (resp_now)
                rdata_buf <= dbus_rdata;
        end
    end

    // Next state and request; any register load returns the FSM to IDLE.
    always_comb begin
        next_state = state;
        dbus_req   = 1'b0;
        case (state)
            S_IDLE: begin
                dbus_req = r.mem_en;
                if (r.mem_en && dbus_addr_ok)
                    next_state = S_WAIT;
            end
            S_WAIT: if (dbus_data_ok) next_state = S_DONE;
            S_DONE: next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
        if (reg_load)
            next_state = S_IDLE;
    end

    assign dbus_wen   = dbus_req ? r.mem_wen : 4'b0000;
    assign dbus_addr  = dbus_req ? r.addr    : 32'h0;
    assign dbus_wdata = dbus_req ? r.wdata   : 32'h0;

    assign stallreq_for_mem = r.mem_en & ~((state == S_DONE) | resp_now);

    // Load data: live bus word on the response cycle, buffered word after.
    always_comb begin
        raw = resp_now ? dbus_rdata : rdata_buf;
        case (r.addr[1:0])
            2'd0:    ld_byte = raw[7:0];
            2'd1:    ld_byte = raw[15:8];
            2'd2:    ld_byte = raw[23:16];
            default: ld_byte = raw[31:24];
        endcase
        ld_half = r.addr[1] ? raw[31:16] : raw[15:0];
        case (r.load_op)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'h0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'h0, ld_half};
            OP_LW:   ld_val = raw;
            default: ld_val = raw;
        endcase
    end

    assign wb_pc       = r.pc;
    assign wb_rf_waddr = r.rf_waddr;
    assign wb_rf_wdata = r.sel_rf_res ? ld_val : r.addr;
    assign wb_hi       = r.hi;
    assign wb_lo       = r.lo;
    assign wb_rf_we    = r.rf_we & ~stallreq_for_mem;
    assign wb_hi_we    = r.hi_we & ~stallreq_for_mem;
    assign wb_lo_we    = r.lo_we & ~stallreq_for_mem;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage. The bench plays EX, the stall
// controller and the data-bus slave, and predicts outputs per instruction.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [31:0] ex_pc, ex_addr, ex_wdata, ex_hi, ex_lo;
    logic        ex_mem_en, ex_sel_rf_res, ex_rf_we, ex_hi_we, ex_lo_we;
    logic [3:0]  ex_mem_wen;
    logic [2:0]  ex_load_op;
    logic [4:0]  ex_rf_waddr;
    logic        dbus_req, dbus_addr_ok, dbus_data_ok;
    logic [3:0]  dbus_wen;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic        stallreq_for_mem;
    logic [31:0] wb_pc, wb_rf_wdata, wb_hi, wb_lo;
    logic        wb_rf_we, wb_hi_we, wb_lo_we;
    logic [4:0]  wb_rf_waddr;

    mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_pc(ex_pc), .ex_mem_en(ex_mem_en), .ex_mem_wen(ex_mem_wen),
        .ex_load_op(ex_load_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_sel_rf_res(ex_sel_rf_res), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .ex_hi_we(ex_hi_we), .ex_lo_we(ex_lo_we),
        .ex_hi(ex_hi), .ex_lo(ex_lo),
        .dbus_req(dbus_req), .dbus_wen(dbus_wen), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_addr_ok(dbus_addr_ok),
        .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
        .stallreq_for_mem(stallreq_for_mem),
        .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
        .wb_rf_wdata(wb_rf_wdata), .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we),
        .wb_hi(wb_hi), .wb_lo(wb_lo)
    );

    always #5 clk = ~clk;

    localparam int N_DIR   = 9;
    localparam int N_TOT   = 300;
    localparam int RST_K   = 150;
    localparam int MAX_CYC = 20000;

    // One instruction plus the bench's bookkeeping of its bus transaction.
    typedef struct {
        logic [31:0] pc, addr, wdata, hi, lo, expv, rd_word;
        logic        mem_en, sel, rf_we, hi_we, lo_we, has_exp, rst_mid, acc, done;
        logic [3:0]  wen;
        logic [2:0]  lop;
        logic [4:0]  waddr;
        int          addr_lat, data_lat, pre, hold, req_cnt, dcnt, stall_cyc, n_acc;
    } ins_t;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mem [16];
    ins_t        dir [N_DIR];
    ins_t        cur, exc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t blank();
        ins_t t;
        t = '{default: '0};
        return t;
    endfunction

    // Load result straight from the rules: shift out the lane, mask, extend.
    function automatic logic [31:0] ref_load(logic [2:0] op, logic [31:0] w, logic [31:0] a);
        logic [31:0] v;
        case (op)
            3'd2, 3'd3: begin
                v = (w >> (8 * a[1:0])) & 32'hFF;
                if (op == 3'd2 && v >= 32'd128) v = v - 32'd256;
            end
            3'd4, 3'd5: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (op == 3'd4 && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic ins_t mk_ld(logic [2:0] op, logic [31:0] a, int al, int dl, logic [31:0] ev);
        ins_t t = blank();
        t.mem_en = 1; t.sel = 1; t.rf_we = 1; t.lop = op; t.addr = a;
        t.addr_lat = al; t.data_lat = dl; t.has_exp = 1; t.expv = ev; t.waddr = 5'd8;
        return t;
    endfunction

    function automatic ins_t mk_alu(logic [31:0] a, logic [4:0] rd);
        ins_t t = blank();
        t.rf_we = 1; t.addr = a; t.waddr = rd; t.has_exp = 1; t.expv = a;
        return t;
    endfunction

    function automatic ins_t gen(int k);
        ins_t t;
        logic [3:0] wt [8];
        wt = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
        if (k < N_DIR) begin
            t = dir[k];
        end else begin
            t = blank();
            t.addr = $urandom; t.waddr = 5'($urandom); t.hi = $urandom; t.lo = $urandom;
            t.addr_lat = $urandom_range(0, 3); t.data_lat = $urandom_range(1, 4);
            t.pre  = ($urandom % 8 == 0) ? 1 : 0;
            t.hold = ($urandom % 6 == 0) ? $urandom_range(1, 3) : 0;
            case ($urandom % 4)
                0: begin t.rf_we = 1; t.hi_we = 1'($urandom); t.lo_we = 1'($urandom); end
                1: begin t.mem_en = 1; t.sel = 1; t.rf_we = 1; t.lop = 3'($urandom_range(1, 5)); end
                2: begin t.mem_en = 1; t.wen = wt[$urandom % 8]; t.wdata = $urandom; end
                default: ;
            endcase
            if (k == RST_K) begin
                t.mem_en = 1; t.sel = 1; t.rf_we = 1; t.lop = 3'd1; t.wen = 4'h0;
                t.addr_lat = 0; t.data_lat = 5; t.rst_mid = 1;
            end
        end
        t.pc = 32'h0040_0000 + 32'(k * 4);
        return t;
    endfunction

    task automatic retire(input ins_t t);
        if (t.mem_en) begin
            chk("n_accept", 32'(t.n_acc), 32'd1);
            chk("stall_cycles", 32'(t.stall_cyc), 32'(t.addr_lat + t.data_lat));
        end
        if (t.has_exp) chk("dir_value", wb_rf_wdata, t.expv);
    endtask

    initial begin
        int          cyc, nret, ngen;
        logic        exp_req, exp_sr, aok, dok, hold_app, bub_app;
        logic [31:0] rd;
        logic [5:0]  ext;

        rst = 1'b1; stall = '0;
        ex_pc = '0; ex_addr = '0; ex_wdata = '0; ex_hi = '0; ex_lo = '0;
        ex_mem_en = 0; ex_sel_rf_res = 0; ex_rf_we = 0; ex_hi_we = 0; ex_lo_we = 0;
        ex_mem_wen = '0; ex_load_op = '0; ex_rf_waddr = '0;
        dbus_addr_ok = 0; dbus_data_ok = 0; dbus_rdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h8011_2233; mem[1] = 32'h9ABC_1234; mem[3] = 32'h1234_5678;

        dir[0] = mk_ld(3'd2, 32'h1003, 0, 1, 32'hFFFF_FF80);
        dir[1] = mk_ld(3'd3, 32'h1003, 0, 1, 32'h0000_0080);
        dir[2] = mk_ld(3'd4, 32'h1006, 2, 3, 32'hFFFF_9ABC);
        dir[3] = mk_ld(3'd5, 32'h1006, 0, 2, 32'h0000_9ABC);
        dir[4] = blank();
        dir[4].mem_en = 1; dir[4].wen = 4'hF; dir[4].addr = 32'h1008;
        dir[4].wdata = 32'hDEAD_BEEF; dir[4].addr_lat = 0; dir[4].data_lat = 1;
        dir[5] = mk_ld(3'd1, 32'h100C, 0, 1, 32'h1234_5678);
        dir[5].hold = 3;
        dir[6] = mk_alu(32'h55, 5'd5);
        dir[7] = mk_ld(3'd1, 32'h1008, 0, 1, 32'hDEAD_BEEF);
        dir[8] = mk_alu(32'h77, 5'd7);
        dir[8].pre = 1;

        #3;
        chk("rst_req", dbus_req, 0);
        chk("rst_stallreq", stallreq_for_mem, 0);
        chk("rst_wb_pc", wb_pc, 0);
        chk("rst_wb", {wb_rf_we, wb_hi_we, wb_lo_we, wb_rf_waddr}, 0);
        chk("rst_wb_data", wb_rf_wdata | wb_hi | wb_lo, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        cur = blank(); exc = gen(0); ngen = 1; nret = 0; cyc = 0;
        while (nret < N_TOT && cyc < MAX_CYC) begin
            cyc++;
            ex_pc = exc.pc; ex_mem_en = exc.mem_en; ex_mem_wen = exc.wen;
            ex_load_op = exc.lop; ex_addr = exc.addr; ex_wdata = exc.wdata;
            ex_sel_rf_res = exc.sel; ex_rf_we = exc.rf_we; ex_rf_waddr = exc.waddr;
            ex_hi_we = exc.hi_we; ex_lo_we = exc.lo_we; ex_hi = exc.hi; ex_lo = exc.lo;

            exp_req = cur.mem_en && !cur.acc;
            aok = exp_req ? (cur.req_cnt == cur.addr_lat) : 1'($urandom);
            dok = cur.acc && !cur.done && (cur.dcnt == cur.data_lat);
            rd  = (dok && cur.wen == 4'h0) ? mem[cur.addr[5:2]] : $urandom;
            dbus_addr_ok = aok; dbus_data_ok = dok; dbus_rdata = rd;

            exp_sr = cur.mem_en && !(cur.done || dok);
            hold_app = 0; bub_app = 0; ext = 6'b0;
            if (!exp_sr) begin
                if (cur.hold > 0 && (!cur.mem_en || cur.done || dok)) begin
                    ext = 6'b011000; hold_app = 1;
                end else if (exc.pre > 0) begin
                    ext = 6'b001000; bub_app = 1;
                end
            end
            stall = exp_sr ? 6'b011111 : ext;

            #1;
            chk("req", dbus_req, exp_req);
            chk("stallreq", stallreq_for_mem, exp_sr);
            chk("wb_pc", wb_pc, cur.pc);
            chk("wb_rf_we", wb_rf_we, cur.rf_we & !exp_sr);
            chk("wb_hi_we", wb_hi_we, cur.hi_we & !exp_sr);
            chk("wb_lo_we", wb_lo_we, cur.lo_we & !exp_sr);
            chk("wb_waddr", wb_rf_waddr, cur.waddr);
            chk("wb_hi", wb_hi, cur.hi);
            chk("wb_lo", wb_lo, cur.lo);
            chk("bus_addr", dbus_addr, exp_req ? cur.addr : 32'h0);
            chk("bus_wen", dbus_wen, exp_req ? cur.wen : 4'h0);
            chk("bus_wdata", dbus_wdata, exp_req ? cur.wdata : 32'h0);
            if (!cur.sel)
                chk("wb_wdata_alu", wb_rf_wdata, cur.addr);
            else if (cur.done || dok)
                chk("wb_wdata_ld", wb_rf_wdata, ref_load(cur.lop, dok ? rd : cur.rd_word, cur.addr));

            if (cur.rst_mid && cur.acc && !cur.done && cur.dcnt == 2) begin
                #2 rst = 1'b1;
                #1;
                chk("midrst_req", dbus_req, 0);
                chk("midrst_stallreq", stallreq_for_mem, 0);
                chk("midrst_wb", {wb_rf_we, wb_hi_we, wb_lo_we, wb_rf_waddr}, 0);
                chk("midrst_wb_pc", wb_pc, 0);
                chk("midrst_wb_data", wb_rf_wdata | wb_hi | wb_lo, 0);
                @(negedge clk);
                rst = 1'b0;
                cur = blank();
                continue;
            end

            if (exp_sr) cur.stall_cyc++;
            if (hold_app) cur.hold--;
            if (bub_app) exc.pre--;
            if (cur.acc && !cur.done) begin
                if (dok) begin
                    cur.done = 1; cur.rd_word = rd;
                    for (int b = 0; b < 4; b++)
                        if (cur.wen[b]) mem[cur.addr[5:2]][8*b +: 8] = cur.wdata[8*b +: 8];
                end else begin
                    cur.dcnt++;
                end
            end
            if (exp_req) begin
                if (aok) begin cur.acc = 1; cur.n_acc++; cur.dcnt = 1; end
                else cur.req_cnt++;
            end
            if (!stall[3]) begin
                retire(cur);
                cur = exc; exc = gen(ngen); ngen++; nret++;
            end else if (!stall[4]) begin
                retire(cur);
                cur = blank();
            end
            @(negedge clk);
        end
        if (nret < N_TOT) chk("timeout", 32'(nret), 32'(N_TOT));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, directly downstream of EX. Holds the EX/MEM pipeline register and issues the load/store on a variable-latency request/response data bus. It also extracts and sign/zero-extends load data and produces the writeback and ID-forwarding results. While an access is outstanding it raises a stall request to the stall controller.

## Interface
Parameters: none.

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  6  stall bus from controller; bit 3 = EX/MEM register hold, bit 4 = MEM/WB register hold
- ex_pc  in  32  PC of instruction leaving EX
- ex_mem_en  in  1  instruction accesses data memory
- ex_mem_wen  in  4  byte-lane write enables, already lane-aligned (0000 = load)
- ex_load_op  in  3  000 none, 001 LW, 010 LB, 011 LBU, 100 LH, 101 LHU
- ex_addr  in  32  ALU result; the memory address for loads/stores
- ex_wdata  in  32  store data, already lane-aligned
- ex_sel_rf_res  in  1  1 = writeback value is load data, 0 = ex_addr (ALU result)
- ex_rf_we, ex_rf_waddr  in  1, 5  GPR write enable / index
- ex_hi_we, ex_lo_we  in  1, 1  HI/LO write enables
- ex_hi, ex_lo  in  32, 32  HI/LO write values
- dbus_req  out  1  request valid
- dbus_wen  out  4  byte write enables (0000 = read)
- dbus_addr  out  32  byte address
- dbus_wdata  out  32  write data
- dbus_addr_ok  in  1  request accepted this cycle (with dbus_req)
- dbus_data_ok  in  1  response this cycle (read data or write done)
- dbus_rdata  in  32  read data, valid with dbus_data_ok
- stallreq_for_mem  out  1  access not yet complete
- wb_pc  out  32  PC to WB
- wb_rf_we, wb_rf_waddr, wb_rf_wdata  out  1, 5, 32  GPR writeback to WB; same signals drive the MEM→ID forwarding path
- wb_hi_we, wb_lo_we, wb_hi, wb_lo  out  1, 1, 32, 32  HI/LO writeback to WB and ID forwarding

## Operation
- Pipeline register, async reset to all-zero:
  - stall[3]=Stop and stall[4]=NoStop: load bubble (all-zero).
  - Else stall[3]=NoStop: load all ex_* fields.
  - Else hold.
- Access FSM, reset to IDLE.
  - States: IDLE, WAIT (request accepted, awaiting response), DONE (response received, register held).
  - IDLE: dbus_req = mem_en. IDLE→WAIT on dbus_req & dbus_addr_ok.
  - WAIT: dbus_req = 0. On dbus_data_ok, capture dbus_rdata into rdata_buf. If the register loads that edge, go to IDLE; otherwise go to DONE.
  - DONE: dbus_req = 0. Go to IDLE on any edge where the register loads (new instruction or bubble).
  - A register load always forces IDLE. It cannot occur in IDLE/WAIT with mem_en=1 because stallreq_for_mem is high there.
- dbus_wen, dbus_addr, dbus_wdata come from registered mem_wen, addr, wdata. They are zero while dbus_req=0.
- stallreq_for_mem = mem_en & ~(state==DONE | (state==WAIT & dbus_data_ok)). The controller answers with stall=6'b011111, so the register holds and WB takes a bubble.
- Raw load word = dbus_rdata in WAIT with data_ok; otherwise rdata_buf.
- Extraction with a = addr[1:0]:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: addr[1]=0 selects [15:0], 1 selects [31:16]; sign- or zero-extended. addr[0] is ignored.
  - LW: whole word, addr[1:0] ignored.
  - No alignment exceptions.
- wb_rf_wdata = sel_rf_res ? extracted load : registered addr.
- Gating: wb_rf_we, wb_hi_we and wb_lo_we are forced 0 while stallreq_for_mem=1. The other wb_* outputs pass the registered values unchanged.
- Stores also wait for dbus_data_ok. Stores carry rf_we=0.

## Timing
- Reset: every output is 0, including dbus_req and stallreq_for_mem. An assert in mid-transaction drops dbus_req immediately; the bus slave shares rst.
- Non-memory instruction: zero stall; outputs valid the cycle after capture.
- Memory access with addr_ok in the request cycle (C0) and data_ok in C1:
  - stallreq_for_mem is high in C0 and low in C1.
  - The result is valid in C1. One stall cycle in total.
- Each extra cycle of addr_ok or data_ok latency adds exactly one stall cycle.
- dbus_req is held with constant addr/wen/wdata until addr_ok. Only one request is ever outstanding.
- Response then external hold (stall[3]=Stop from another cause): DONE holds the result from rdata_buf with no re-request.

## Test plan
- Reset: assert rst mid-WAIT → dbus_req, stallreq_for_mem and all wb_* are 0 asynchronously; after release the FSM is IDLE with no request.
- Zero-wait LB, addr 0x1003, rdata 0x80112233 → one stall cycle; wb_rf_wdata=0xFFFFFF80. LBU same → 0x00000080.
- LH with addr[1]=1, rdata 0x9ABC1234, addr_ok delayed 2 cycles, data_ok 3 cycles after acceptance → stall for 5 cycles; wb_rf_wdata=0xFFFF9ABC. LHU → 0x00009ABC.
- SW, wen 1111, wdata 0xDEADBEEF → exactly one accepted request with dbus_wen=1111; wb_rf_we=0 throughout.
- Data_ok arrives while stall[3]=Stop from another source for 3 cycles → DONE; no second dbus_req; LW result 0x12345678 held from buffer until the register advances.
- Back-to-back ADD then LW → ADD forwards with no stall; LW issues its request the cycle after ADD leaves; stall[3]=Stop with stall[4]=NoStop injects a bubble (wb_rf_we=0).
